// File: rtl/valid_sweep_controller.sv
// valid_sweep_controller
// Sits between the cache controller and the valid-bit array. The array has
// no reset, so after reset and on every flush request this block walks every
// index and writes 0. Outside a sweep it arbitrates the read/write port
// between invalidate, fill and port-0 lookup. Port-1 lookups pass straight
// through to the read-only port.

module valid_sweep_controller #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o,
  input  logic                  inval_i,
  input  logic [ADDR_WIDTH-1:0] inval_address_i,
  input  logic                  fill_i,
  input  logic [ADDR_WIDTH-1:0] fill_address_i,
  input  logic [1:0]            lookup_i,
  input  logic [ADDR_WIDTH-1:0] lookup0_address_i,
  input  logic [ADDR_WIDTH-1:0] lookup1_address_i,
  output logic                  inval_gnt_o,
  output logic                  fill_gnt_o,
  output logic [1:0]            lookup_gnt_o,
  output logic [1:0]            lookup_rvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_rw_address_o,
  output logic                  mem_valid_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_read_address_o,
  output logic [1:0]            mem_read_o
);

  typedef enum logic [1:0] {
    INIT_SWEEP,
    IDLE,
    FLUSH_SWEEP
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   count;
  logic                    sweeping;
  logic                    last_entry;
  logic                    serve;

  assign sweeping   = (state == INIT_SWEEP) || (state == FLUSH_SWEEP);
  assign last_entry = (count == '1);
  // Grants and memory strobes are gated by rst_n_i directly so they drop the
  // moment reset asserts, without waiting for the state register.
  assign serve      = rst_n_i && (state == IDLE);

  // Fixed-priority arbitration of the read/write port; port 1 is never contended.
  always_comb begin
    inval_gnt_o     = serve && inval_i;
    fill_gnt_o      = serve && fill_i && !inval_i;
    lookup_gnt_o[0] = serve && lookup_i[0] && !inval_i && !fill_i;
    lookup_gnt_o[1] = serve && lookup_i[1];
  end

  // Memory port steering: sweep writes, or whichever requester won the port.
  always_comb begin
    mem_rw_address_o   = '0;
    mem_valid_o        = 1'b0;
    mem_write_o        = 1'b0;
    mem_read_address_o = '0;
    mem_read_o         = '0;
    if (rst_n_i && sweeping) begin
      mem_write_o      = 1'b1;
      mem_rw_address_o = count;
    end else if (inval_gnt_o) begin
      mem_write_o      = 1'b1;
      mem_rw_address_o = inval_address_i;
    end else if (fill_gnt_o) begin
      mem_write_o      = 1'b1;
      mem_valid_o      = 1'b1;
      mem_rw_address_o = fill_address_i;
    end else if (lookup_gnt_o[0]) begin
      mem_read_o[0]    = 1'b1;
      mem_rw_address_o = lookup0_address_i;
    end
    if (lookup_gnt_o[1]) begin
      mem_read_o[1]      = 1'b1;
      mem_read_address_o = lookup1_address_i;
    end
  end

  // Sweep sequencer with registered busy, done pulse and read-valid outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= INIT_SWEEP;
      count           <= '0;
      busy_o          <= 1'b1;
      flush_done_o    <= 1'b0;
      lookup_rvalid_o <= '0;
    end else begin
      flush_done_o    <= 1'b0;
      lookup_rvalid_o <= lookup_gnt_o;
      case (state)
        INIT_SWEEP, FLUSH_SWEEP: begin
          // flush_i is ignored here: a request mid-sweep is already satisfied
          count <= count + ADDR_WIDTH'(1);
          if (last_entry) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            flush_done_o <= 1'b1;
          end
        end
        IDLE: begin
          if (flush_i) begin
            state  <= FLUSH_SWEEP;
            busy_o <= 1'b1;
            count  <= '0;
          end
        end
        default: begin
          state  <= INIT_SWEEP;
          busy_o <= 1'b1;
          count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valid_sweep_controller.sv
// Bench for valid_sweep_controller with ADDR_WIDTH=4, including a behavioural
// valid-bit array (one read/write port, one read-only port, registered reads).

module tb_valid_sweep_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned N  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          busy;
  logic          flush_done;
  logic          inval;
  logic [AW-1:0] inval_addr;
  logic          fill;
  logic [AW-1:0] fill_addr;
  logic [1:0]    lookup;
  logic [AW-1:0] lookup0_addr;
  logic [AW-1:0] lookup1_addr;
  logic          inval_gnt;
  logic          fill_gnt;
  logic [1:0]    lookup_gnt;
  logic [1:0]    lookup_rvalid;
  logic [AW-1:0] mem_rw_addr;
  logic          mem_valid;
  logic          mem_write;
  logic [AW-1:0] mem_read_addr;
  logic [1:0]    mem_read;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Memory powers up with every bit set so an incomplete sweep is visible.
  logic [N-1:0] mem = '1;
  logic         rdata0;
  logic         rdata1;

  // Bench's own picture of which lines should be valid.
  logic [N-1:0] ref_valid = '0;
  logic         q0[$];
  logic         q1[$];

  valid_sweep_controller #(.ADDR_WIDTH(AW)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .flush_i            (flush),
    .busy_o             (busy),
    .flush_done_o       (flush_done),
    .inval_i            (inval),
    .inval_address_i    (inval_addr),
    .fill_i             (fill),
    .fill_address_i     (fill_addr),
    .lookup_i           (lookup),
    .lookup0_address_i  (lookup0_addr),
    .lookup1_address_i  (lookup1_addr),
    .inval_gnt_o        (inval_gnt),
    .fill_gnt_o         (fill_gnt),
    .lookup_gnt_o       (lookup_gnt),
    .lookup_rvalid_o    (lookup_rvalid),
    .mem_rw_address_o   (mem_rw_addr),
    .mem_valid_o        (mem_valid),
    .mem_write_o        (mem_write),
    .mem_read_address_o (mem_read_addr),
    .mem_read_o         (mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural valid-bit array: write-first is irrelevant on port 0, and
  // port 1 sees the pre-write value in the same cycle.
  always @(posedge clk) begin
    if (mem_read[0]) rdata0 <= mem[mem_rw_addr];
    if (mem_read[1]) rdata1 <= mem[mem_read_addr];
    if (mem_write)   mem[mem_rw_addr] <= mem_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected read data whenever the DUT flags a valid read.
  always @(negedge clk) begin
    if (rst_n && lookup_rvalid[0]) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 1, 0);
      else                check("rdata0", rdata0, q0.pop_front());
    end
    if (rst_n && lookup_rvalid[1]) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 1, 0);
      else                check("rdata1", rdata1, q1.pop_front());
    end
  end

  task automatic drive_quiet();
    flush = 1'b0; inval = 1'b0; fill = 1'b0; lookup = 2'b00;
    inval_addr = '0; fill_addr = '0; lookup0_addr = '0; lookup1_addr = '0;
  endtask

  // One IDLE cycle; eg = expected {lookup1, lookup0, fill, inval} grants.
  task automatic cycle(input string tag, input logic fl,
                       input logic inv, input int unsigned ia,
                       input logic fil, input int unsigned fa,
                       input logic [1:0] lk, input int unsigned l0a, input int unsigned l1a,
                       input logic [3:0] eg);
    flush = fl; inval = inv; fill = fil; lookup = lk;
    inval_addr = AW'(ia); fill_addr = AW'(fa);
    lookup0_addr = AW'(l0a); lookup1_addr = AW'(l1a);
    #1;
    check({tag, "_gnt"}, {lookup_gnt, fill_gnt, inval_gnt}, eg);
    if (eg[2]) q0.push_back(ref_valid[AW'(l0a)]);
    if (eg[3]) q1.push_back(ref_valid[AW'(l1a)]);
    if (eg[0]) ref_valid[AW'(ia)] = 1'b0;
    if (eg[1]) ref_valid[AW'(fa)] = 1'b1;
    @(negedge clk);
    drive_quiet();
  endtask

  // Checks a full sweep starting at the current negedge, then the done pulse.
  task automatic sweep(input string tag, input logic hold_req, input int unsigned reflush_at);
    for (int unsigned i = 0; i < N; i++) begin
      inval = hold_req; fill = hold_req; lookup = {2{hold_req}};
      inval_addr = AW'(i); fill_addr = AW'(i + 1);
      lookup0_addr = AW'(i + 2); lookup1_addr = AW'(i + 3);
      flush = (i == reflush_at);
      #1;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_wr"}, mem_write, 1);
      check({tag, "_addr"}, mem_rw_addr, i);
      check({tag, "_val"}, mem_valid, 0);
      check({tag, "_gnt"}, {lookup_gnt, fill_gnt, inval_gnt}, 0);
      check({tag, "_rd"}, mem_read, 0);
      check({tag, "_done_early"}, flush_done, 0);
      @(negedge clk);
    end
    drive_quiet();
    #1;
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done"}, flush_done, 1);
    ref_valid = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      check({tag, "_done_once"}, flush_done, 0);
      check({tag, "_busy_after"}, busy, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_quiet();
    inval = 1'b1; fill = 1'b1; lookup = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_done", flush_done, 0);
    check("rst_rvalid", lookup_rvalid, 0);
    check("rst_gnt", {lookup_gnt, fill_gnt, inval_gnt}, 0);
    check("rst_wr", mem_write, 0);
    check("rst_rd", mem_read, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("init", 1'b0, N);

    // Untouched line reads 0 on both ports after the reset sweep.
    cycle("init_lk", 0, 0, 0, 0, 0, 2'b11, 11, 12, 4'b1100);

    // Fill then lookup on port 0.
    cycle("fill5", 0, 0, 0, 1, 5, 2'b00, 0, 0, 4'b0010);
    cycle("lk5",   0, 0, 0, 0, 0, 2'b01, 5, 0, 4'b0100);

    // Priority: inval > fill > lookup0, all on line 3; port 1 reads old value.
    cycle("pre3",  0, 0, 0, 1, 3, 2'b00, 0, 0, 4'b0010);
    cycle("pri_a", 0, 1, 3, 1, 3, 2'b01, 3, 0, 4'b0001);
    cycle("pri_b", 0, 0, 0, 1, 3, 2'b11, 3, 3, 4'b1010);
    cycle("pri_c", 0, 0, 0, 0, 0, 2'b01, 3, 0, 4'b0100);

    // Fill 1, 2, 7; flush with a same-cycle fill still granted.
    cycle("fill1", 0, 0, 0, 1, 1, 2'b00, 0, 0, 4'b0010);
    cycle("fill2", 0, 0, 0, 1, 2, 2'b00, 0, 0, 4'b0010);
    cycle("fill7", 0, 0, 0, 1, 7, 2'b10, 0, 1, 4'b1010);
    cycle("lk7",   0, 0, 0, 0, 0, 2'b11, 7, 2, 4'b1100);
    cycle("flush_fill", 1, 0, 0, 1, 4, 2'b00, 0, 0, 4'b0010);
    sweep("flush", 1'b1, N);
    cycle("post1", 0, 0, 0, 0, 0, 2'b11, 1, 1, 4'b1100);
    cycle("post2", 0, 0, 0, 0, 0, 2'b11, 2, 2, 4'b1100);
    cycle("post7", 0, 0, 0, 0, 0, 2'b11, 7, 4, 4'b1100);

    // Second flush request mid-sweep is absorbed.
    cycle("reflush_go", 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
    sweep("reflush", 1'b0, 5);

    // Reset in the middle of a flush sweep; line 9 survives the aborted sweep.
    cycle("fill9", 0, 0, 0, 1, 9, 2'b00, 0, 0, 4'b0010);
    cycle("abort_go", 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
    inval = 1'b1; fill = 1'b1; lookup = 2'b11;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_done", flush_done, 0);
    check("midrst_rvalid", lookup_rvalid, 0);
    check("midrst_gnt", {lookup_gnt, fill_gnt, inval_gnt}, 0);
    check("midrst_wr", mem_write, 0);
    check("midrst_rd", mem_read, 0);
    repeat (2) @(negedge clk);
    drive_quiet();
    rst_n = 1'b1;
    sweep("resweep", 1'b1, N);
    cycle("post9", 0, 0, 0, 0, 0, 2'b11, 9, 9, 4'b1100);
    cycle("post9b", 0, 0, 0, 0, 0, 2'b01, 0, 0, 4'b0100);

    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/valid_sweep_controller.md
# valid_sweep_controller

Sequencer and arbiter in front of a cache line valid-bit memory with one read/write port and one read-only port. After reset, and on every flush request, it clears every valid bit by sweeping all addresses, since the memory has no reset of its own. Outside a sweep it shares the read/write port between line invalidation, line fill and port-0 lookup. Port-1 lookups pass straight through. It sits between the cache controller and the valid-bit array.

## Interface
- ADDR_WIDTH, 8, cache index width; the sweep covers 2**ADDR_WIDTH entries.

- clk_i  in  1  clock, all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  request a full invalidation sweep
- busy_o  out  1  sweep in progress; no requester is granted
- flush_done_o  out  1  one-cycle pulse in the cycle after the last entry is cleared
- inval_i / inval_address_i  in  1 / ADDR_WIDTH  clear one entry
- fill_i / fill_address_i  in  1 / ADDR_WIDTH  set one entry
- lookup_i  in  2  lookup request per read port
- lookup0_address_i / lookup1_address_i  in  ADDR_WIDTH  lookup indices
- inval_gnt_o, fill_gnt_o  out  1  request accepted this cycle (combinational)
- lookup_gnt_o  out  2  lookup accepted this cycle (combinational)
- lookup_rvalid_o  out  2  registered copy of lookup_gnt_o; memory read data is valid
- mem_rw_address_o  out  ADDR_WIDTH  to the memory read/write address
- mem_valid_o  out  1  write data to the memory
- mem_write_o  out  1  write strobe to the memory
- mem_read_address_o  out  ADDR_WIDTH  to the memory read-only port address
- mem_read_o  out  2  read enables to the memory

## Operation
- States: INIT_SWEEP, IDLE, FLUSH_SWEEP. Index counter is ADDR_WIDTH bits wide.
- Reset values:
  - State INIT_SWEEP, counter 0.
  - busy_o=1; flush_done_o=0; lookup_rvalid_o=0.
  - While rst_n_i=0, all grants and mem_write_o/mem_read_o are forced 0.
- INIT_SWEEP / FLUSH_SWEEP behaviour:
  - Drive mem_write_o=1, mem_valid_o=0, mem_rw_address_o=counter, mem_read_o=0.
  - busy_o=1 and all grants are 0.
  - The counter increments each cycle.
- Leaving a sweep: in the cycle that writes counter=2**ADDR_WIDTH-1, the counter wraps to 0, the next state is IDLE, and flush_done_o=1 the following cycle. This applies to both sweep states, so the reset sweep also ends with a done pulse.
- IDLE, read/write port priority:
  - inval_i first: write 0 at inval_address_i.
  - Then fill_i: write 1 at fill_address_i.
  - Then lookup_i[0]: mem_read_o[0]=1 at lookup0_address_i.
  - Exactly one of these is granted per cycle; the losers see gnt=0 and must hold their request.
- Port 1 in IDLE: lookup_i[1] is always granted. mem_read_o[1]=1 and mem_read_address_o=lookup1_address_i.
- When nothing on the read/write port is granted, mem_write_o=0 and mem_read_o[0]=0. Addresses are don't-care but must be stable (drive 0).
- Simultaneous inval and fill to the same address: inval is granted and fill stalls one cycle, then writes 1. The final state is valid.
- flush_i in IDLE:
  - Grants in the same cycle are still honoured.
  - The next state is FLUSH_SWEEP with counter=0.
- flush_i during either sweep is absorbed. It causes no restart and no extra flush_done_o pulse.
- Reset asserted mid-sweep: the sweep aborts immediately, and a full INIT_SWEEP runs again after release.

## Timing
- Sweep length is exactly 2**ADDR_WIDTH cycles with busy_o=1. flush_done_o fires on cycle 2**ADDR_WIDTH after sweep start, when busy_o is already 0.
- First grant possible: cycle 2**ADDR_WIDTH after reset release, the same cycle as the INIT done pulse.
- Write latency: an entry granted at edge N holds its new value from edge N+1.
- Read latency: lookup_rvalid_o[k] is high in the cycle after lookup_gnt_o[k], aligned with memory read data.
- Write/read ordering on port 0: a lookup granted in the cycle after a fill to the same index returns 1.
- Cross-port ordering on port 1: a port-1 lookup in the same cycle as a port-0 write returns the old value. There is no forwarding.

## Test plan
- Reset release with ADDR_WIDTH=4 -> busy_o=1 for exactly 16 cycles; mem_write_o=1 with addresses 0..15 and mem_valid_o=0; then flush_done_o pulses once and busy_o=0.
- Fill at 0x05, then lookup0 at 0x05 -> fill_gnt_o=1; the next cycle lookup_gnt_o[0]=1; one cycle later lookup_rvalid_o[0]=1 with memory data 1.
- inval, fill and lookup0 all at 0x3 in one cycle -> grant order inval, then fill, then lookup0 over 3 cycles; the lookup returns 1.
- Fill lines 1, 2 and 7, then flush_i pulse -> 2**ADDR_WIDTH cycles with busy_o=1 and zero grants; after flush_done_o, lookups on both ports at 1, 2 and 7 return 0.
- Second flush_i 5 cycles into a sweep -> the sweep is not extended and exactly one flush_done_o pulse occurs.
- rst_n_i low midway through FLUSH_SWEEP -> outputs take their reset values immediately; after release, a full sweep from address 0 runs with one done pulse.
